// File: rtl/uart_input_manager.sv
// uart_input_manager: UART 8N1 receiver plus line parser.
// Serial bytes from RsRx are assembled into a CR-terminated line of ASCII hex
// digits. The parsed value and an error code are presented together with a
// one-cycle ready_out strobe.
//
// RX FSM states
//   state   | meaning
//   S_IDLE  | line idle, watching for a falling edge (start bit)
//   S_START | waiting half a bit to confirm the start bit is real
//   S_DATA  | sampling data bits at mid-bit, LSB first
//   S_STOP  | sampling the stop bit; fires the byte strobe or a framing error
//
// Error codes: 0 ok, 1 invalid character, 2 too many digits, 3 framing error.
module uart_input_manager #(
  parameter int DATA_SIZE  = 4,
  parameter int CLOCK_RATE = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int ASCII_SIZE = 8,
  parameter int HEX_SIZE   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          RsRx,
  output logic [DATA_SIZE*HEX_SIZE-1:0] data_out,
  output logic [1:0]                    error_out,
  output logic                          ready_out
);

  localparam int CLKS_PER_BIT = CLOCK_RATE / BAUD_RATE;
  // Guard against a zero half-bit load at very low oversampling ratios.
  localparam int HALF_BIT     = (CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 : 1;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam int BIT_W        = (ASCII_SIZE > 1) ? $clog2(ASCII_SIZE) : 1;
  localparam int DIG_W        = $clog2(DATA_SIZE + 1);
  localparam int VAL_W        = DATA_SIZE * HEX_SIZE;

  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(ASCII_SIZE - 1);
  localparam logic [DIG_W-1:0] MAX_DIG   = DIG_W'(DATA_SIZE);

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_CHAR  = 2'd1;
  localparam logic [1:0] ERR_LEN   = 2'd2;
  localparam logic [1:0] ERR_FRAME = 2'd3;

  localparam logic [ASCII_SIZE-1:0] CH_0       = ASCII_SIZE'(8'h30);
  localparam logic [ASCII_SIZE-1:0] CH_9       = ASCII_SIZE'(8'h39);
  localparam logic [ASCII_SIZE-1:0] CH_UP_A    = ASCII_SIZE'(8'h41);
  localparam logic [ASCII_SIZE-1:0] CH_UP_F    = ASCII_SIZE'(8'h46);
  localparam logic [ASCII_SIZE-1:0] CH_LOW_A   = ASCII_SIZE'(8'h61);
  localparam logic [ASCII_SIZE-1:0] CH_LOW_F   = ASCII_SIZE'(8'h66);
  localparam logic [ASCII_SIZE-1:0] CH_NL      = ASCII_SIZE'(8'h0A);
  localparam logic [ASCII_SIZE-1:0] CH_CR      = ASCII_SIZE'(8'h0D);
  localparam logic [ASCII_SIZE-1:0] HEX_OFFSET = ASCII_SIZE'(10);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } rx_state_t;

  logic sync1_q, sync2_q;

  rx_state_t             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [ASCII_SIZE-1:0] shift_q, shift_d;
  logic                  byte_stb;
  logic                  frame_err;

  logic                  is_hex;
  logic [HEX_SIZE-1:0]   nibble;

  logic [VAL_W-1:0]      acc_q, acc_d;
  logic [DIG_W-1:0]      dig_q, dig_d;
  logic [1:0]            err_q, err_d;
  logic [VAL_W-1:0]      data_q, data_d;
  logic [1:0]            eout_q, eout_d;
  logic                  rdy_q, rdy_d;

  // Two-flop synchroniser for the asynchronous serial line; idles high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= RsRx;
      sync2_q <= sync1_q;
    end
  end

  // RX FSM state, bit-time down-counter, bit index and shift register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // RX next-state: every sample is taken when the down-counter reaches zero.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    byte_stb  = 1'b0;
    frame_err = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!sync2_q) begin
          state_d = S_START;
          cnt_d   = HALF_LOAD;
        end
      end
      S_START: begin
        if (cnt_q == '0) begin
          if (!sync2_q) begin
            state_d = S_DATA;
            cnt_d   = FULL_LOAD;
            bit_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          shift_d = {sync2_q, shift_q[ASCII_SIZE-1:1]};
          cnt_d   = FULL_LOAD;
          if (bit_q == LAST_BIT) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          if (sync2_q) begin
            byte_stb = 1'b1;
          end else begin
            frame_err = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Classify the received byte as a hex digit and extract its nibble value.
  always_comb begin
    is_hex = 1'b0;
    nibble = '0;
    if (shift_q >= CH_0 && shift_q <= CH_9) begin
      is_hex = 1'b1;
      nibble = HEX_SIZE'(shift_q - CH_0);
    end else if (shift_q >= CH_UP_A && shift_q <= CH_UP_F) begin
      is_hex = 1'b1;
      nibble = HEX_SIZE'(shift_q - CH_UP_A + HEX_OFFSET);
    end else if (shift_q >= CH_LOW_A && shift_q <= CH_LOW_F) begin
      is_hex = 1'b1;
      nibble = HEX_SIZE'(shift_q - CH_LOW_A + HEX_OFFSET);
    end
  end

  // Line parser: accumulate digits, latch the first error, publish on CR.
  always_comb begin
    acc_d  = acc_q;
    dig_d  = dig_q;
    err_d  = err_q;
    data_d = data_q;
    eout_d = eout_q;
    rdy_d  = 1'b0;
    if (frame_err) begin
      // The damaged byte is dropped, even if it was meant to be the CR.
      if (err_q == ERR_NONE) begin
        err_d = ERR_FRAME;
      end
    end else if (byte_stb) begin
      if (is_hex) begin
        if (err_q == ERR_NONE) begin
          if (dig_q < MAX_DIG) begin
            acc_d = (acc_q << HEX_SIZE) | VAL_W'(nibble);
            dig_d = dig_q + 1'b1;
          end else begin
            err_d = ERR_LEN;
          end
        end
      end else if (shift_q == CH_NL) begin
        // LF is ignored so CR LF terminated lines parse cleanly.
      end else if (shift_q == CH_CR) begin
        if (err_q != ERR_NONE || dig_q != '0) begin
          rdy_d  = 1'b1;
          data_d = (err_q == ERR_NONE) ? acc_q : '0;
          eout_d = err_q;
          acc_d  = '0;
          dig_d  = '0;
          err_d  = ERR_NONE;
        end
      end else if (err_q == ERR_NONE) begin
        err_d = ERR_CHAR;
      end
    end
  end

  // Parser registers and the held output value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q  <= '0;
      dig_q  <= '0;
      err_q  <= ERR_NONE;
      data_q <= '0;
      eout_q <= ERR_NONE;
      rdy_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      dig_q  <= dig_d;
      err_q  <= err_d;
      data_q <= data_d;
      eout_q <= eout_d;
      rdy_q  <= rdy_d;
    end
  end

  assign data_out  = data_q;
  assign error_out = eout_q;
  assign ready_out = rdy_q;

endmodule

// File: tb/tb_uart_input_manager.sv
// Testbench for uart_input_manager: drives 8N1 frames at 16 clocks per bit
// and checks every ready_out pulse against a line-level reference model.
`timescale 1ns/1ps
module tb_uart_input_manager;

  localparam int DS  = 4;
  localparam int CPB = 16;
  // Edges from driving the stop bit to ready_out: 2 sync + half bit + 1.
  localparam int STOP_TO_READY = 2 + CPB / 2 + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        RsRx = 1'b1;
  logic [15:0] data_out;
  logic [1:0]  error_out;
  logic        ready_out;

  always #5 clk = ~clk;

  uart_input_manager #(
    .DATA_SIZE (DS),
    .CLOCK_RATE(16),
    .BAUD_RATE (1),
    .ASCII_SIZE(8),
    .HEX_SIZE  (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .RsRx     (RsRx),
    .data_out (data_out),
    .error_out(error_out),
    .ready_out(ready_out)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic [15:0] obs_data[$];
  logic [1:0]  obs_err[$];
  int          obs_cyc[$];
  logic [15:0] exp_data[$];
  logic [1:0]  exp_err[$];
  int          exp_cyc[$];

  // Reference model state: one open line.
  int          mdig = 0;
  int          merr = 0;
  int unsigned mval = 0;
  logic [15:0] hold_data = 16'h0;
  logic [1:0]  hold_err = 2'd0;
  int          last_stop_cyc = 0;

  // Every cycle with ready_out high is recorded as one pulse.
  always @(negedge clk) begin
    if (ready_out === 1'b1) begin
      obs_data.push_back(data_out);
      obs_err.push_back(error_out);
      obs_cyc.push_back(cyc);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic bit is_hex(input logic [7:0] b);
    return (b >= 8'h30 && b <= 8'h39) || (b >= 8'h41 && b <= 8'h46) ||
           (b >= 8'h61 && b <= 8'h66);
  endfunction

  function automatic int hexval(input logic [7:0] b);
    if (b <= 8'h39) return int'(b) - 48;
    if (b <= 8'h46) return int'(b) - 55;
    return int'(b) - 87;
  endfunction

  task automatic model_reset();
    mdig = 0;
    merr = 0;
    mval = 0;
    hold_data = 16'h0;
    hold_err = 2'd0;
  endtask

  task automatic model_byte(input logic [7:0] b, input logic ok);
    logic [15:0] d;
    if (!ok) begin
      if (merr == 0) merr = 3;
    end else if (is_hex(b)) begin
      if (merr == 0) begin
        if (mdig < DS) begin
          mval = mval * 16 + hexval(b);
          mdig++;
        end else begin
          merr = 2;
        end
      end
    end else if (b == 8'h0A) begin
    end else if (b == 8'h0D) begin
      if (merr != 0 || mdig != 0) begin
        d = (merr == 0) ? 16'(mval) : 16'h0;
        exp_data.push_back(d);
        exp_err.push_back(2'(merr));
        exp_cyc.push_back(last_stop_cyc + STOP_TO_READY);
        hold_data = d;
        hold_err = 2'(merr);
        mval = 0;
        mdig = 0;
        merr = 0;
      end
    end else if (merr == 0) begin
      merr = 1;
    end
  endtask

  task automatic send_bit(input logic v);
    RsRx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_char(input logic [7:0] b, input logic stop_ok);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    last_stop_cyc = cyc;
    send_bit(stop_ok);
    if (!stop_ok) begin
      send_bit(1'b1);
      send_bit(1'b1);
    end
    model_byte(b, stop_ok);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i], 1'b1);
  endtask

  task automatic drain(input string name);
    int n;
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (obs_data.size() != exp_data.size()) begin
      errors++;
      $display("FAIL %s pulse_count: got %0d expected %0d", name, obs_data.size(), exp_data.size());
    end
    n = (obs_data.size() < exp_data.size()) ? obs_data.size() : exp_data.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (obs_data[i] !== exp_data[i]) begin
        errors++;
        $display("FAIL %s data[%0d]: got %h expected %h", name, i, obs_data[i], exp_data[i]);
      end
      checks++;
      if (obs_err[i] !== exp_err[i]) begin
        errors++;
        $display("FAIL %s error[%0d]: got %0d expected %0d", name, i, obs_err[i], exp_err[i]);
      end
      checks++;
      if (obs_cyc[i] != exp_cyc[i]) begin
        errors++;
        $display("FAIL %s pulse_cycle[%0d]: got %0d expected %0d", name, i, obs_cyc[i], exp_cyc[i]);
      end
    end
    checks++;
    if (data_out !== hold_data || error_out !== hold_err) begin
      errors++;
      $display("FAIL %s hold: got %h/%0d expected %h/%0d", name, data_out, error_out, hold_data, hold_err);
    end
    obs_data.delete();
    obs_err.delete();
    obs_cyc.delete();
    exp_data.delete();
    exp_err.delete();
    exp_cyc.delete();
  endtask

  task automatic check_zero_outputs(input string name);
    checks++;
    if (data_out !== 16'h0 || error_out !== 2'd0 || ready_out !== 1'b0) begin
      errors++;
      $display("FAIL %s: got data=%h err=%0d ready=%b expected 0000/0/0", name, data_out, error_out, ready_out);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    RsRx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset_state");
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_zero_outputs("after_reset");
    model_reset();
  endtask

  task automatic test_basic();
    send_str("1A3F\r");
    drain("basic_1A3F");
  endtask

  task automatic test_lf_empty();
    send_str("a\r\n");
    send_str("\r");
    drain("lf_and_empty_line");
  endtask

  task automatic test_invalid();
    send_str("12G4\r");
    drain("invalid_char");
    send_str("0042\r");
    drain("after_invalid");
  endtask

  task automatic test_overflow();
    send_str("12345\r");
    drain("too_many_digits");
    send_str("12#345\r");
    drain("first_error_kept");
  endtask

  task automatic test_framing();
    send_char("5", 1'b0);
    send_str("\r");
    drain("framing_error");
    RsRx = 1'b0;
    repeat (CPB / 2) @(posedge clk);
    #1;
    RsRx = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    #1;
    send_str("\r");
    drain("glitch_no_byte");
    send_str("9\r");
    drain("after_glitch");
    send_char(8'h0D, 1'b0);
    send_str("\r");
    drain("framing_on_cr");
  endtask

  task automatic test_random();
    logic [7:0] c;
    int r, d, nch;
    for (int line = 0; line < 8; line++) begin
      nch = $urandom_range(1, 5);
      for (int j = 0; j < nch; j++) begin
        r = $urandom_range(0, 99);
        d = $urandom_range(0, 15);
        if (d < 10) c = 8'(48 + d);
        else if ($urandom_range(0, 1) == 1) c = 8'(55 + d);
        else c = 8'(87 + d);
        if (r < 72) begin
          send_char(c, 1'b1);
        end else if (r < 82) begin
          do c = 8'($urandom_range(32, 126)); while (is_hex(c));
          send_char(c, 1'b1);
        end else if (r < 90) begin
          send_char(8'h0A, 1'b1);
        end else begin
          send_char(c, 1'b0);
        end
        if ($urandom_range(0, 3) == 0) begin
          repeat ($urandom_range(1, 20)) @(posedge clk);
          #1;
        end
      end
      send_str("\r");
      drain("random_line");
    end
  endtask

  task automatic test_reset_midframe();
    send_str("BEEF\r");
    drain("before_reset");
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    RsRx = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_zero_outputs("async_reset_mid_data");
    RsRx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("held_in_reset");
    reset = 1'b0;
    model_reset();
    repeat (12 * CPB) @(posedge clk);
    #1;
    drain("aborted_frame_silent");
    send_str("7\r");
    drain("after_reset_7");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lf_empty();
    test_invalid();
    test_overflow();
    test_framing();
    test_random();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
